// File: rtl/datapath_pkg.sv
// datapath_pkg: shared defaults, slice-width helper and op/mode encodings for datapath units
package datapath_pkg;
  localparam int DEFAULT_DATAWIDTH = 64;
  localparam int DEFAULT_STAGES = 4;
  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;
  localparam logic MODE_UNS = 1'b0;
  localparam logic MODE_SGN = 1'b1;
  function automatic int slice_w(input int dw, input int st);
    return dw / st;
  endfunction
endpackage

// File: rtl/pipe_add_stage.sv
// pipe_add_stage: one W-bit carry-chain slice with registered sum/carry-out, valid bit and load logic
//   Clk, Rst            clock, async active-high reset
//   prev_valid          upstream register (or in_valid) holds a transaction
//   next_load           downstream stage loads this cycle (or out_ready for the last stage)
//   a_s, b_s, cin       slice operands (b already inverted for subtract) and carry-in
//   valid, load         this stage holds data / loads on the next edge
//   s, co               registered slice sum and carry-out
module pipe_add_stage #(
  parameter int W = 16
) (
  input  logic         Clk,
  input  logic         Rst,
  input  logic         prev_valid,
  input  logic         next_load,
  input  logic [W-1:0] a_s,
  input  logic [W-1:0] b_s,
  input  logic         cin,
  output logic         valid,
  output logic         load,
  output logic [W-1:0] s,
  output logic         co
);
  assign load = ~valid | next_load;
  always_ff @(posedge Clk or posedge Rst)
    if (Rst) begin
      valid <= 1'b0;
      s <= '0;
      co <= 1'b0;
    end else if (load) begin
      valid <= prev_valid;
      if (prev_valid) {co, s} <= {1'b0, a_s} + {1'b0, b_s} + {{W{1'b0}}, cin};
    end
endmodule

// File: rtl/pipe_add.sv
// pipe_add: pipelined add/subtract with valid/ready handshake, carry and overflow flags
//   Clk, Rst                 clock, async active-high reset
//   in_valid/in_ready        input handshake for a, b, sub (1: a-b), is_signed (1: two's-complement flags)
//   out_valid/out_ready      output handshake for sum, carry (raw MSB carry-out), ovf
//   Macro PIPE_ADD_SAT_EN: clamp sum on overflow instead of wrapping.
module pipe_add
  import datapath_pkg::*;
#(
  parameter int DATAWIDTH = DEFAULT_DATAWIDTH,
  parameter int STAGES = DEFAULT_STAGES
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DATAWIDTH-1:0] a,
  input  logic [DATAWIDTH-1:0] b,
  input  logic                 sub,
  input  logic                 is_signed,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DATAWIDTH-1:0] sum,
  output logic                 carry,
  output logic                 ovf
);
  localparam int W = slice_w(DATAWIDTH, STAGES);
  // Each stage registers full-width operands (b post-inversion), the finished low sum slices and the op mode;
  // acc merges the low slices with this stage's own registered slice.
  for (genvar k = 0; k < STAGES; k++) begin : g
    logic [DATAWIDTH-1:0] ra, rb, lo, acc, a_i, b_i, lo_i;
    logic rsb, rsg, sb_i, sg_i, v_i, c_i, nl, v, ld, co;
    logic [W-1:0] s;
    if (k == 0) begin : h
      assign a_i = a;
      assign b_i = b ^ {DATAWIDTH{sub}};
      assign lo_i = '0;
      assign sb_i = sub;
      assign sg_i = is_signed;
      assign v_i = in_valid;
      assign c_i = sub;
    end else begin : h
      assign a_i = g[k-1].ra;
      assign b_i = g[k-1].rb;
      assign lo_i = g[k-1].acc;
      assign sb_i = g[k-1].rsb;
      assign sg_i = g[k-1].rsg;
      assign v_i = g[k-1].v;
      assign c_i = g[k-1].co;
    end
    if (k == STAGES - 1) begin : n
      assign nl = out_ready;
    end else begin : n
      assign nl = g[k+1].ld;
    end
    pipe_add_stage #(.W(W)) u_stage (
      .Clk(Clk),
      .Rst(Rst),
      .prev_valid(v_i),
      .next_load(nl),
      .a_s(a_i[k*W +: W]),
      .b_s(b_i[k*W +: W]),
      .cin(c_i),
      .valid(v),
      .load(ld),
      .s(s),
      .co(co)
    );
    always_ff @(posedge Clk or posedge Rst)
      if (Rst) {ra, rb, lo, rsb, rsg} <= '0;
      else if (ld & v_i) {ra, rb, lo, rsb, rsg} <= {a_i, b_i, lo_i, sb_i, sg_i};
    assign acc = lo | (DATAWIDTH'(s) << (k * W));
  end
  logic [DATAWIDTH-1:0] raw;
  logic am, bm, sm, sb, sg;
  assign in_ready = g[0].ld;
  assign out_valid = g[STAGES-1].v;
  assign raw = g[STAGES-1].acc;
  assign carry = g[STAGES-1].co;
  assign am = g[STAGES-1].ra[DATAWIDTH-1];
  assign bm = g[STAGES-1].rb[DATAWIDTH-1];
  assign sm = raw[DATAWIDTH-1];
  assign sb = g[STAGES-1].rsb;
  assign sg = g[STAGES-1].rsg;
  assign ovf = (sg == MODE_SGN) ? ((am == bm) & (sm != am)) : ((sb == OP_SUB) ? ~carry : carry);
`ifdef PIPE_ADD_SAT_EN
  // Signed overflow direction follows the A sign: positive clamps to 011..1, negative to 100..0.
  assign sum = ~ovf ? raw : (sg == MODE_SGN) ? {am, {(DATAWIDTH-1){~am}}} : {DATAWIDTH{sb == OP_ADD}};
`else
  assign sum = raw;
`endif
endmodule

// File: tb/tb_pipe_add.sv
// tb_pipe_add: directed self-checking bench for pipe_add (8/2 and 64/4 configurations)
module tb_pipe_add;
  logic Clk = 1'b0, Rst = 1'b1;
  always #5 Clk = ~Clk;
  int checks = 0, errors = 0;
  logic i8v = 0, i8r, sub8 = 0, sg8 = 0, o8v, o8r = 1, c8, v8;
  logic [7:0] a8 = 0, b8 = 0, s8;
  logic i64v = 0, i64r, sub64 = 0, sg64 = 0, o64v, o64r = 1, c64, v64;
  logic [63:0] a64 = 0, b64 = 0, s64;

  pipe_add #(.DATAWIDTH(8), .STAGES(2)) dut8 (
    .Clk(Clk), .Rst(Rst), .in_valid(i8v), .in_ready(i8r), .a(a8), .b(b8), .sub(sub8),
    .is_signed(sg8), .out_valid(o8v), .out_ready(o8r), .sum(s8), .carry(c8), .ovf(v8));
  pipe_add #(.DATAWIDTH(64), .STAGES(4)) dut64 (
    .Clk(Clk), .Rst(Rst), .in_valid(i64v), .in_ready(i64r), .a(a64), .b(b64), .sub(sub64),
    .is_signed(sg64), .out_valid(o64v), .out_ready(o64r), .sum(s64), .carry(c64), .ovf(v64));

  task automatic txn8(input logic [7:0] a, b, input logic sb, sg,
                      output logic [7:0] s, output logic c, o, output int lat);
    @(negedge Clk);
    a8 = a; b8 = b; sub8 = sb; sg8 = sg; i8v = 1; lat = 0;
    do begin
      @(negedge Clk);
      i8v = 0;
      lat++;
    end while (!o8v && lat < 10);
    s = s8; c = c8; o = v8;
  endtask

  task automatic test_reset;
    #12;
    checks++; if (o8v !== 1'b0 || s8 !== 8'h00 || c8 !== 1'b0 || v8 !== 1'b0) begin errors++;
      $display("FAIL reset8 got v=%b s=%h c=%b o=%b want 0/00/0/0", o8v, s8, c8, v8); end
    checks++; if (o64v !== 1'b0 || s64 !== 64'h0 || c64 !== 1'b0 || v64 !== 1'b0) begin errors++;
      $display("FAIL reset64 got v=%b s=%h c=%b o=%b want 0/0/0/0", o64v, s64, c64, v64); end
    @(negedge Clk); Rst = 0; #1;
    checks++; if (i8r !== 1'b1 || i64r !== 1'b1) begin errors++;
      $display("FAIL reset_ready got %b %b want 1 1", i8r, i64r); end
  endtask

  task automatic test_unsigned_add;
    logic [7:0] s; logic c, o; int lat;
    txn8(8'h7F, 8'h01, 0, 0, s, c, o, lat);
    checks++; if (lat !== 2) begin errors++; $display("FAIL uadd_lat got %0d want 2", lat); end
    checks++; if (s !== 8'h80) begin errors++; $display("FAIL uadd_sum got %h want 80", s); end
    checks++; if (c !== 1'b0 || o !== 1'b0) begin errors++; $display("FAIL uadd_flags got c=%b o=%b want 0 0", c, o); end
    txn8(8'hFF, 8'h02, 0, 0, s, c, o, lat);
`ifdef PIPE_ADD_SAT_EN
    checks++; if (s !== 8'hFF) begin errors++; $display("FAIL uadd_wrap_sum got %h want ff", s); end
`else
    checks++; if (s !== 8'h01) begin errors++; $display("FAIL uadd_wrap_sum got %h want 01", s); end
`endif
    checks++; if (c !== 1'b1 || o !== 1'b1) begin errors++; $display("FAIL uadd_wrap_flags got c=%b o=%b want 1 1", c, o); end
  endtask

  task automatic test_signed;
    logic [7:0] s; logic c, o; int lat;
    txn8(8'h7F, 8'h01, 0, 1, s, c, o, lat);
`ifdef PIPE_ADD_SAT_EN
    checks++; if (s !== 8'h7F) begin errors++; $display("FAIL sadd_sum got %h want 7f", s); end
`else
    checks++; if (s !== 8'h80) begin errors++; $display("FAIL sadd_sum got %h want 80", s); end
`endif
    checks++; if (c !== 1'b0 || o !== 1'b1) begin errors++; $display("FAIL sadd_flags got c=%b o=%b want 0 1", c, o); end
    txn8(8'h80, 8'h01, 1, 1, s, c, o, lat);
`ifdef PIPE_ADD_SAT_EN
    checks++; if (s !== 8'h80) begin errors++; $display("FAIL ssub_sum got %h want 80", s); end
`else
    checks++; if (s !== 8'h7F) begin errors++; $display("FAIL ssub_sum got %h want 7f", s); end
`endif
    checks++; if (c !== 1'b1 || o !== 1'b1) begin errors++; $display("FAIL ssub_flags got c=%b o=%b want 1 1", c, o); end
  endtask

  task automatic test_unsigned_sub;
    logic [7:0] s; logic c, o; int lat;
    txn8(8'h05, 8'h09, 1, 0, s, c, o, lat);
`ifdef PIPE_ADD_SAT_EN
    checks++; if (s !== 8'h00) begin errors++; $display("FAIL usub_sum got %h want 00", s); end
`else
    checks++; if (s !== 8'hFC) begin errors++; $display("FAIL usub_sum got %h want fc", s); end
`endif
    checks++; if (c !== 1'b0 || o !== 1'b1) begin errors++; $display("FAIL usub_flags got c=%b o=%b want 0 1", c, o); end
    txn8(8'h09, 8'h05, 1, 0, s, c, o, lat);
    checks++; if (s !== 8'h04 || c !== 1'b1 || o !== 1'b0) begin errors++;
      $display("FAIL usub_nb got s=%h c=%b o=%b want 04 1 0", s, c, o); end
  endtask

  task automatic test_back_to_back;
    logic [63:0] ta[4], tb[4], ex[4];
    logic ts[4], ec[4];
    ta = '{64'h0000_0000_FFFF_FFFF, 64'h1234_5678_9ABC_DEF0, 64'h0000_0001_0000_0000, 64'h00FF_00FF_00FF_00FF};
    tb = '{64'h1, 64'h1111_1111_1111_1111, 64'h1, 64'h0F0F_0F0F_0F0F_0F0F};
    ts = '{0, 0, 1, 0};
    ex = '{64'h0000_0001_0000_0000, 64'h2345_6789_ABCD_F001, 64'h0000_0000_FFFF_FFFF, 64'h100E_100E_100E_100E};
    ec = '{0, 0, 1, 0};
    o64r = 1;
    @(negedge Clk);
    for (int n = 0; n <= 8; n++) begin
      if (n >= 4 && n <= 7) begin
        checks++; if (o64v !== 1'b1 || s64 !== ex[n-4] || c64 !== ec[n-4] || v64 !== 1'b0) begin errors++;
          $display("FAIL b2b_%0d got v=%b s=%h c=%b o=%b want 1 %h %b 0", n - 4, o64v, s64, c64, v64, ex[n-4], ec[n-4]); end
      end
      if (n == 8) begin
        checks++; if (o64v !== 1'b0) begin errors++; $display("FAIL b2b_drain got v=%b want 0", o64v); end
      end
      if (n < 4) begin
        checks++; if (i64r !== 1'b1) begin errors++; $display("FAIL b2b_ready_%0d got %b want 1", n, i64r); end
        i64v = 1; a64 = ta[n]; b64 = tb[n]; sub64 = ts[n]; sg64 = 0;
      end else i64v = 0;
      @(negedge Clk);
    end
  endtask

  task automatic test_back_pressure;
    logic [63:0] d[5], ex[5];
    int acc = 0, got = 0;
    d = '{64'h1, 64'h2, 64'h3, 64'h4, 64'h5};
    ex = '{64'h0000_0001_0000_0001, 64'h0000_0001_0000_0002, 64'h0000_0001_0000_0003,
           64'h0000_0001_0000_0004, 64'h0000_0001_0000_0005};
    b64 = 64'h0000_0001_0000_0000; sub64 = 0; sg64 = 0; o64r = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge Clk);
      i64v = 1; a64 = d[acc < 5 ? acc : 4];
      #1;
      if (i64r) acc++;
      if (c == 5) begin
        checks++; if (o64v !== 1'b1 || s64 !== ex[0]) begin errors++;
          $display("FAIL bp_hold_mid got v=%b s=%h want 1 %h", o64v, s64, ex[0]); end
      end
    end
    checks++; if (acc !== 4) begin errors++; $display("FAIL bp_accepted got %0d want 4", acc); end
    checks++; if (i64r !== 1'b0) begin errors++; $display("FAIL bp_full_ready got %b want 0", i64r); end
    checks++; if (o64v !== 1'b1 || s64 !== ex[0]) begin errors++;
      $display("FAIL bp_hold_end got v=%b s=%h want 1 %h", o64v, s64, ex[0]); end
    @(negedge Clk);
    for (int c = 0; c < 10; c++) begin
      if (c == 0) begin
        o64r = 1; i64v = 1; a64 = d[4];
        #1;
        checks++; if (i64r !== 1'b1) begin errors++; $display("FAIL bp_simul_ready got %b want 1", i64r); end
      end else i64v = 0;
      if (o64v && got < 5) begin
        checks++; if (s64 !== ex[got]) begin errors++; $display("FAIL bp_drain_%0d got %h want %h", got, s64, ex[got]); end
        got++;
      end
      @(negedge Clk);
    end
    checks++; if (got !== 5 || o64v !== 1'b0) begin errors++;
      $display("FAIL bp_count got %0d v=%b want 5 0", got, o64v); end
  endtask

  task automatic test_reset_flight;
    int n = 0, stale = 0, lat = 0;
    b64 = 64'h10; sub64 = 0; sg64 = 0; o64r = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge Clk);
      i64v = 1; a64 = 64'(i + 1);
    end
    @(negedge Clk); i64v = 0;
    while (!o64v && n < 10) begin @(negedge Clk); n++; end
    checks++; if (o64v !== 1'b1 || s64 !== 64'h11) begin errors++;
      $display("FAIL rst_pre got v=%b s=%h want 1 11", o64v, s64); end
    #2 Rst = 1;
    #1;
    checks++; if (o64v !== 1'b0 || s64 !== 64'h0 || c64 !== 1'b0 || v64 !== 1'b0) begin errors++;
      $display("FAIL rst_async got v=%b s=%h c=%b o=%b want 0 0 0 0", o64v, s64, c64, v64); end
    @(negedge Clk); Rst = 0; o64r = 1;
    for (int c = 0; c < 8; c++) begin @(negedge Clk); if (o64v) stale++; end
    checks++; if (stale !== 0) begin errors++; $display("FAIL rst_stale got %0d want 0", stale); end
    a64 = 64'h5; b64 = 64'h7; i64v = 1;
    do begin @(negedge Clk); i64v = 0; lat++; end while (!o64v && lat < 10);
    checks++; if (lat !== 4 || s64 !== 64'hC) begin errors++;
      $display("FAIL rst_next got lat=%0d s=%h want 4 c", lat, s64); end
  endtask

  initial begin
    test_reset;
    test_unsigned_add;
    test_signed;
    test_unsigned_sub;
    test_back_to_back;
    test_back_pressure;
    test_reset_flight;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
